// File: rtl/mips_pkg.sv
// mips_pkg: shared encodings, latency defaults and match helpers for the hazard controller
package mips_pkg;
  localparam logic [1:0] FWD_REG = 2'b00;
  localparam logic [1:0] FWD_WB  = 2'b01;
  localparam logic [1:0] FWD_MEM = 2'b10;
  localparam int MULT_LAT_DEF = 4;
  localparam int DIV_LAT_DEF  = 32;
  typedef enum logic {MD_IDLE = 1'b0, MD_BUSY = 1'b1} md_state_e;
  // Register 0 is hardwired, so a zero destination never creates a dependency
  function automatic logic reads_reg(input logic [4:0] rd, rs, rt, input logic use_rs, use_rt);
    return (rd != 5'd0) && ((use_rs && rd == rs) || (use_rt && rd == rt));
  endfunction
  function automatic logic [1:0] fwd_sel(input logic [4:0] src, mem_rd, wb_rd, input logic mem_we, wb_we);
    return (mem_we && mem_rd != 5'd0 && mem_rd == src) ? FWD_MEM :
           (wb_we && wb_rd != 5'd0 && wb_rd == src) ? FWD_WB : FWD_REG;
  endfunction
endpackage

// File: rtl/md_occupancy_counter.sv
// md_occupancy_counter: tracks how long the MULT/DIV unit stays busy after an accepted start
module md_occupancy_counter
  import mips_pkg::*;
#(
  parameter int MULT_LAT = MULT_LAT_DEF,
  parameter int DIV_LAT  = DIV_LAT_DEF
) (
  input  logic clk,
  input  logic rst_n,
  input  logic start,
  input  logic is_div,
  output logic busy,
  output logic done
);
  localparam int MAX_LAT = (DIV_LAT > MULT_LAT) ? DIV_LAT : MULT_LAT;
  localparam int CW = (MAX_LAT > 1) ? $clog2(MAX_LAT) : 1;
  md_state_e state_q, state_d;
  logic [CW-1:0] count_q, count_d;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= MD_IDLE;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
    end
  end
  // count holds the busy cycles remaining after the current one
  always_comb begin
    state_d = state_q;
    count_d = count_q;
    if (state_q == MD_IDLE) begin
      state_d = start ? MD_BUSY : MD_IDLE;
      count_d = is_div ? CW'(DIV_LAT - 1) : CW'(MULT_LAT - 1);
    end else begin
      state_d = (count_q == '0) ? MD_IDLE : MD_BUSY;
      count_d = (count_q == '0) ? count_q : count_q - 1'b1;
    end
  end
  always_comb begin
    busy = (state_q == MD_BUSY);
    done = busy && (count_q == '0);
  end
endmodule

// File: rtl/hazard_controller.sv
// hazard_controller: ID-stage stall/flush generation, EX forwarding selects and MULT/DIV occupancy
module hazard_controller
  import mips_pkg::*;
#(
  parameter int MULT_LAT = MULT_LAT_DEF,
  parameter int DIV_LAT  = DIV_LAT_DEF,
  parameter int CNT_W    = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [4:0]       id_rs,
  input  logic [4:0]       id_rt,
  input  logic             id_use_rs,
  input  logic             id_use_rt,
  input  logic             id_branch,
  input  logic             id_branch_taken,
  input  logic             id_md_start,
  input  logic             id_md_div,
  input  logic             id_hilo_read,
  input  logic [4:0]       ex_rs,
  input  logic [4:0]       ex_rt,
  input  logic [4:0]       ex_rd,
  input  logic             ex_reg_write,
  input  logic             ex_mem_read,
  input  logic [4:0]       mem_rd,
  input  logic             mem_reg_write,
  input  logic             mem_mem_read,
  input  logic [4:0]       wb_rd,
  input  logic             wb_reg_write,
  output logic             pc_en,
  output logic             if_id_en,
  output logic             if_id_flush,
  output logic             id_ex_flush,
  output logic [1:0]       fwd_a,
  output logic [1:0]       fwd_b,
  output logic             md_busy,
  output logic             md_done,
  output logic [CNT_W-1:0] stall_cycles
);
  logic load_use, branch_hz, md_hz, stall;
  logic [CNT_W-1:0] stall_q;
  always_comb begin
    load_use    = ex_mem_read && reads_reg(ex_rd, id_rs, id_rt, id_use_rs, id_use_rt);
    // Branches compare in ID, so even ALU results still in EX are too late
    branch_hz   = id_branch &&
                  ((ex_reg_write && reads_reg(ex_rd, id_rs, id_rt, id_use_rs, id_use_rt)) ||
                   (mem_mem_read && reads_reg(mem_rd, id_rs, id_rt, id_use_rs, id_use_rt)));
    md_hz       = md_busy && (id_md_start || id_hilo_read);
    stall       = load_use || branch_hz || md_hz;
    pc_en       = !stall;
    if_id_en    = !stall;
    id_ex_flush = stall;
    if_id_flush = id_branch && id_branch_taken && !stall;
    fwd_a       = fwd_sel(ex_rs, mem_rd, wb_rd, mem_reg_write, wb_reg_write);
    fwd_b       = fwd_sel(ex_rt, mem_rd, wb_rd, mem_reg_write, wb_reg_write);
  end
  md_occupancy_counter #(
    .MULT_LAT(MULT_LAT),
    .DIV_LAT (DIV_LAT)
  ) u_md (
    .clk   (clk),
    .rst_n (rst_n),
    .start (id_md_start && !stall),
    .is_div(id_md_div),
    .busy  (md_busy),
    .done  (md_done)
  );
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) stall_q <= '0;
    else if (!pc_en && !(&stall_q)) stall_q <= stall_q + 1'b1;
  end
  assign stall_cycles = stall_q;
endmodule

// File: tb/tb_hazard_controller.sv
// tb_hazard_controller: directed stimulus with a scoreboard queue drained by a negedge monitor
module tb_hazard_controller;
  logic clk = 1'b0;
  logic rst_n;
  logic [4:0] id_rs, id_rt, ex_rs, ex_rt, ex_rd, mem_rd, wb_rd;
  logic id_use_rs, id_use_rt, id_branch, id_branch_taken, id_md_start, id_md_div, id_hilo_read;
  logic ex_reg_write, ex_mem_read, mem_reg_write, mem_mem_read, wb_reg_write;
  logic pc_en, if_id_en, if_id_flush, id_ex_flush, md_busy, md_done;
  logic [1:0] fwd_a, fwd_b;
  logic [15:0] stall_cycles;
  logic s_pc_en, s_if_id_en, s_if_id_flush, s_id_ex_flush, s_md_busy, s_md_done;
  logic [1:0] s_fwd_a, s_fwd_b;
  logic [3:0] s_stall_cycles;

  typedef struct {
    logic pe; logic ff; logic [1:0] fa; logic [1:0] fb;
    logic mb; logic md; logic [15:0] sc; logic [3:0] sc4;
  } exp_t;
  exp_t q[$];
  exp_t e;
  int checks = 0;
  int fails = 0;
  logic [15:0] exp_sc = 16'd0;
  logic [3:0] exp_sc4 = 4'd0;

  always #5 clk = ~clk;

  hazard_controller dut (
    .clk(clk), .rst_n(rst_n), .id_rs(id_rs), .id_rt(id_rt), .id_use_rs(id_use_rs), .id_use_rt(id_use_rt),
    .id_branch(id_branch), .id_branch_taken(id_branch_taken), .id_md_start(id_md_start), .id_md_div(id_md_div),
    .id_hilo_read(id_hilo_read), .ex_rs(ex_rs), .ex_rt(ex_rt), .ex_rd(ex_rd), .ex_reg_write(ex_reg_write),
    .ex_mem_read(ex_mem_read), .mem_rd(mem_rd), .mem_reg_write(mem_reg_write), .mem_mem_read(mem_mem_read),
    .wb_rd(wb_rd), .wb_reg_write(wb_reg_write), .pc_en(pc_en), .if_id_en(if_id_en), .if_id_flush(if_id_flush),
    .id_ex_flush(id_ex_flush), .fwd_a(fwd_a), .fwd_b(fwd_b), .md_busy(md_busy), .md_done(md_done),
    .stall_cycles(stall_cycles)
  );

  hazard_controller #(.CNT_W(4)) dut_s (
    .clk(clk), .rst_n(rst_n), .id_rs(id_rs), .id_rt(id_rt), .id_use_rs(id_use_rs), .id_use_rt(id_use_rt),
    .id_branch(id_branch), .id_branch_taken(id_branch_taken), .id_md_start(id_md_start), .id_md_div(id_md_div),
    .id_hilo_read(id_hilo_read), .ex_rs(ex_rs), .ex_rt(ex_rt), .ex_rd(ex_rd), .ex_reg_write(ex_reg_write),
    .ex_mem_read(ex_mem_read), .mem_rd(mem_rd), .mem_reg_write(mem_reg_write), .mem_mem_read(mem_mem_read),
    .wb_rd(wb_rd), .wb_reg_write(wb_reg_write), .pc_en(s_pc_en), .if_id_en(s_if_id_en),
    .if_id_flush(s_if_id_flush), .id_ex_flush(s_id_ex_flush), .fwd_a(s_fwd_a), .fwd_b(s_fwd_b),
    .md_busy(s_md_busy), .md_done(s_md_done), .stall_cycles(s_stall_cycles)
  );

  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s at %0t: got %0h expected %0h", n, $time, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (q.size() > 0) begin
      e = q.pop_front();
      chk("pc_en", 32'(pc_en), 32'(e.pe));
      chk("if_id_en", 32'(if_id_en), 32'(e.pe));
      chk("id_ex_flush", 32'(id_ex_flush), 32'(!e.pe));
      chk("if_id_flush", 32'(if_id_flush), 32'(e.ff));
      chk("fwd_a", 32'(fwd_a), 32'(e.fa));
      chk("fwd_b", 32'(fwd_b), 32'(e.fb));
      chk("md_busy", 32'(md_busy), 32'(e.mb));
      chk("md_done", 32'(md_done), 32'(e.md));
      chk("stall_cycles", 32'(stall_cycles), 32'(e.sc));
      chk("stall_cycles_w4", 32'(s_stall_cycles), 32'(e.sc4));
    end
  end

  task automatic clr();
    {id_rs, id_rt, ex_rs, ex_rt, ex_rd, mem_rd, wb_rd} = '0;
    {id_use_rs, id_use_rt, id_branch, id_branch_taken, id_md_start, id_md_div, id_hilo_read} = '0;
    {ex_reg_write, ex_mem_read, mem_reg_write, mem_mem_read, wb_reg_write} = '0;
  endtask

  // Queue this cycle's expectation, then advance to just after the next edge
  task automatic tick(input logic pe, input logic ff, input logic [1:0] fa, input logic [1:0] fb,
                      input logic mb, input logic md);
    exp_t x;
    x.pe = pe; x.ff = ff; x.fa = fa; x.fb = fb; x.mb = mb; x.md = md; x.sc = exp_sc; x.sc4 = exp_sc4;
    q.push_back(x);
    @(posedge clk);
    #1;
    if (!pe && rst_n) begin
      if (exp_sc != 16'hFFFF) exp_sc = exp_sc + 16'd1;
      if (exp_sc4 != 4'hF) exp_sc4 = exp_sc4 + 4'd1;
    end
  endtask

  initial begin
    rst_n = 1'b0;
    clr();
    @(posedge clk);
    #1;
    tick(1, 0, 2'b00, 2'b00, 0, 0);
    tick(1, 0, 2'b00, 2'b00, 0, 0);
    rst_n = 1'b1;
    tick(1, 0, 2'b00, 2'b00, 0, 0);
    // load-use on rs, then rt, then ignored cases
    ex_mem_read = 1; ex_rd = 5; id_rs = 5; id_use_rs = 1;
    tick(0, 0, 2'b00, 2'b00, 0, 0);
    clr();
    tick(1, 0, 2'b00, 2'b00, 0, 0);
    ex_mem_read = 1; ex_rd = 0; id_rs = 0; id_use_rs = 1;
    tick(1, 0, 2'b00, 2'b00, 0, 0);
    ex_mem_read = 1; ex_rd = 7; id_rt = 7; id_use_rt = 0;
    tick(1, 0, 2'b00, 2'b00, 0, 0);
    id_use_rt = 1;
    tick(0, 0, 2'b00, 2'b00, 0, 0);
    clr();
    // branches
    id_branch = 1; id_branch_taken = 1;
    tick(1, 1, 2'b00, 2'b00, 0, 0);
    ex_reg_write = 1; ex_rd = 9; id_rt = 9; id_use_rt = 1;
    tick(0, 0, 2'b00, 2'b00, 0, 0);
    clr();
    id_branch = 1; id_branch_taken = 1; mem_rd = 4; id_rs = 4; id_use_rs = 1; mem_reg_write = 1;
    tick(1, 1, 2'b00, 2'b00, 0, 0);
    mem_mem_read = 1;
    tick(0, 0, 2'b00, 2'b00, 0, 0);
    clr();
    id_branch = 1; id_branch_taken = 0;
    tick(1, 0, 2'b00, 2'b00, 0, 0);
    clr();
    // forwarding priority and register 0
    ex_rs = 3; mem_rd = 3; wb_rd = 3; mem_reg_write = 1; wb_reg_write = 1;
    tick(1, 0, 2'b10, 2'b00, 0, 0);
    mem_reg_write = 0;
    tick(1, 0, 2'b01, 2'b00, 0, 0);
    ex_rs = 3; ex_rt = 6; mem_rd = 3; mem_reg_write = 1; wb_rd = 6; wb_reg_write = 1;
    tick(1, 0, 2'b10, 2'b01, 0, 0);
    ex_rs = 0; ex_rt = 0; mem_rd = 0; wb_rd = 0;
    tick(1, 0, 2'b00, 2'b00, 0, 0);
    clr();
    // DIV issued at T, MFHI waiting in ID from T+1
    id_md_start = 1; id_md_div = 1;
    tick(1, 0, 2'b00, 2'b00, 0, 0);
    id_md_start = 0; id_md_div = 0; id_hilo_read = 1;
    for (int k = 1; k <= 32; k++) tick(0, 0, 2'b00, 2'b00, 1, k == 32);
    tick(1, 0, 2'b00, 2'b00, 0, 0);
    clr();
    // MULT at T, a second MULT waits while busy and is accepted on the first idle cycle
    id_md_start = 1;
    tick(1, 0, 2'b00, 2'b00, 0, 0);
    for (int k = 1; k <= 4; k++) tick(0, 0, 2'b00, 2'b00, 1, k == 4);
    tick(1, 0, 2'b00, 2'b00, 0, 0);
    clr();
    for (int k = 1; k <= 4; k++) tick(1, 0, 2'b00, 2'b00, 1, k == 4);
    tick(1, 0, 2'b00, 2'b00, 0, 0);
    // reset in the middle of a DIV clears state without waiting for a clock edge
    id_md_start = 1; id_md_div = 1;
    tick(1, 0, 2'b00, 2'b00, 0, 0);
    clr();
    for (int k = 1; k <= 9; k++) tick(1, 0, 2'b00, 2'b00, 1, 0);
    rst_n = 1'b0;
    exp_sc = 16'd0;
    exp_sc4 = 4'd0;
    tick(1, 0, 2'b00, 2'b00, 0, 0);
    rst_n = 1'b1;
    for (int k = 0; k < 34; k++) tick(1, 0, 2'b00, 2'b00, 0, 0);
    repeat (3) @(negedge clk);
    checks++;
    if (q.size() != 0) begin
      fails++;
      $display("FAIL scoreboard_drain: %0d entries left, expected 0", q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
